// File: rtl/pulse_ctrl.sv
// pulse_ctrl: beat-interval supervisor for a period-averaging datapath.
// Measures ticks between beats, discards artifact beats that come too soon,
// drives the clear/shift strobes of the period counter and the 4-deep period
// chain, and flags loss of signal when no beat arrives within MAX ticks.
module pulse_ctrl #(
   parameter int W      = 6,
   parameter int MIN_PD = 12
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       beat,
   input  logic       tick,
   output logic       pd_clr,
   output logic       shift_en,
   output logic [2:0] nsamp,
   output logic       avg_valid,
   output logic       timeout,
   output logic       reject
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ARM   = 2'd1,
      S_TRACK = 2'd2,
      S_LOST  = 2'd3
   } state_t;

   localparam logic [W-1:0] IVL_MAX  = {W{1'b1}};
   localparam logic [W-1:0] IVL_MIN  = W'(MIN_PD);
   localparam logic [2:0]   NSAMP_FULL = 3'd4;

   state_t       state_q, state_d;
   logic [W-1:0] ivl_q, ivl_d;
   logic [2:0]   nsamp_q, nsamp_d;
   logic         pd_clr_q, pd_clr_d;
   logic         shift_en_q, shift_en_d;
   logic         reject_q, reject_d;
   logic         avg_valid_q, avg_valid_d;
   logic         timeout_q, timeout_d;

   logic         beat_ok;
   logic         ivl_at_max;
   logic [W-1:0] ivl_inc;
   logic [2:0]   nsamp_inc;

   // Interval helpers: judge the beat against the pre-increment count,
   // saturate the count at MAX and the sample count at 4.
   always_comb begin
      ivl_at_max = (ivl_q == IVL_MAX);
      beat_ok    = (ivl_q >= IVL_MIN);
      ivl_inc    = ivl_at_max ? ivl_q : ivl_q + {{(W-1){1'b0}}, 1'b1};
      nsamp_inc  = (nsamp_q >= NSAMP_FULL) ? NSAMP_FULL : nsamp_q + 3'd1;
   end

   // Next-state and registered-output logic; strobes default low every cycle.
   always_comb begin
      state_d    = state_q;
      ivl_d      = ivl_q;
      nsamp_d    = nsamp_q;
      timeout_d  = timeout_q;
      pd_clr_d   = 1'b0;
      shift_en_d = 1'b0;
      reject_d   = 1'b0;

      unique case (state_q)
         S_IDLE, S_LOST: begin
            // No period reference yet: a beat only starts a new measurement.
            ivl_d = '0;
            if (beat) begin
               pd_clr_d  = 1'b1;
               nsamp_d   = 3'd0;
               timeout_d = 1'b0;
               state_d   = S_ARM;
            end
         end

         S_ARM, S_TRACK: begin
            if (beat && beat_ok) begin
               // Accepted beat: the measured period is loaded into the chain
               // and the counters restart. Clearing beats a same-cycle tick.
               pd_clr_d   = 1'b1;
               shift_en_d = 1'b1;
               ivl_d      = '0;
               nsamp_d    = nsamp_inc;
               if (nsamp_inc == NSAMP_FULL) begin
                  state_d = S_TRACK;
               end
            end else if (!beat && ivl_at_max) begin
               // Interval overflow without a beat: signal lost.
               state_d   = S_LOST;
               timeout_d = 1'b1;
               nsamp_d   = 3'd0;
               ivl_d     = '0;
            end else begin
               // Artifact beat (too soon) is flagged but otherwise ignored,
               // so the interval keeps counting from the last accepted beat.
               if (beat) begin
                  reject_d = 1'b1;
               end
               if (tick) begin
                  ivl_d = ivl_inc;
               end
            end
         end

         default: begin
            state_d = S_IDLE;
            ivl_d   = '0;
         end
      endcase

      avg_valid_d = (state_d == S_TRACK);
   end

   // State and output registers, cleared asynchronously by rst.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         ivl_q       <= '0;
         nsamp_q     <= 3'd0;
         pd_clr_q    <= 1'b0;
         shift_en_q  <= 1'b0;
         reject_q    <= 1'b0;
         avg_valid_q <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         ivl_q       <= ivl_d;
         nsamp_q     <= nsamp_d;
         pd_clr_q    <= pd_clr_d;
         shift_en_q  <= shift_en_d;
         reject_q    <= reject_d;
         avg_valid_q <= avg_valid_d;
         timeout_q   <= timeout_d;
      end
   end

   assign pd_clr    = pd_clr_q;
   assign shift_en  = shift_en_q;
   assign reject    = reject_q;
   assign nsamp     = nsamp_q;
   assign avg_valid = avg_valid_q;
   assign timeout   = timeout_q;

endmodule

// File: tb/tb_pulse_ctrl.sv
// tb_pulse_ctrl: directed scoreboard bench for pulse_ctrl (W=6, MIN_PD=12).
module tb_pulse_ctrl;

   logic       clk;
   logic       rst;
   logic       beat;
   logic       tick;
   logic       pd_clr;
   logic       shift_en;
   logic [2:0] nsamp;
   logic       avg_valid;
   logic       timeout;
   logic       reject;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      string      tag;
      logic       pd;
      logic       sh;
      logic       rj;
      logic [2:0] ns;
      logic       av;
      logic       to;
   } exp_t;

   exp_t sb_q[$];

   pulse_ctrl #(.W(6), .MIN_PD(12)) dut (
      .clk       (clk),
      .rst       (rst),
      .beat      (beat),
      .tick      (tick),
      .pd_clr    (pd_clr),
      .shift_en  (shift_en),
      .nsamp     (nsamp),
      .avg_valid (avg_valid),
      .timeout   (timeout),
      .reject    (reject)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      checks++;
      assert (obs === expv)
      else begin
         failures++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // One clock with the given inputs; outputs are sampled 1 time unit after the edge.
   task automatic cycle(input logic b, input logic t);
      beat = b;
      tick = t;
      @(posedge clk);
      #1;
      beat = 1'b0;
      tick = 1'b0;
   endtask

   // n tick cycles with no beat; no strobe may fire.
   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         cycle(1'b0, 1'b1);
         chk("quiet", {5'd0, pd_clr, shift_en, reject}, 8'd0);
      end
   endtask

   // Scoreboarded transaction: expectation pushed with the stimulus,
   // popped and compared once the registered outputs appear.
   task automatic step(input logic b, input logic t, input string tag,
                       input logic pd, input logic sh, input logic rj,
                       input logic [2:0] ns, input logic av, input logic to);
      exp_t e;
      e.tag = tag; e.pd = pd; e.sh = sh; e.rj = rj; e.ns = ns; e.av = av; e.to = to;
      sb_q.push_back(e);
      cycle(b, t);
      e = sb_q.pop_front();
      $display("txn %s: pd_clr=%0d shift_en=%0d reject=%0d nsamp=%0d avg_valid=%0d timeout=%0d",
               e.tag, pd_clr, shift_en, reject, nsamp, avg_valid, timeout);
      chk({e.tag, ".pd_clr"},    8'(pd_clr),    8'(e.pd));
      chk({e.tag, ".shift_en"},  8'(shift_en),  8'(e.sh));
      chk({e.tag, ".reject"},    8'(reject),    8'(e.rj));
      chk({e.tag, ".nsamp"},     8'(nsamp),     8'(e.ns));
      chk({e.tag, ".avg_valid"}, 8'(avg_valid), 8'(e.av));
      chk({e.tag, ".timeout"},   8'(timeout),   8'(e.to));
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".outs"}, {2'd0, pd_clr, shift_en, reject, avg_valid, timeout, 1'b0}, 8'd0);
      chk({tag, ".nsamp"}, 8'(nsamp), 8'd0);
   endtask

   initial begin
      rst  = 1'b1;
      beat = 1'b0;
      tick = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_all_zero("reset_hold");
      rst = 1'b0;

      // Five beats 20 ticks apart: first only clears, next four fill the chain.
      step(1, 0, "b1_idle", 1, 0, 0, 3'd0, 0, 0);
      ticks(20);
      step(1, 0, "b2", 1, 1, 0, 3'd1, 0, 0);
      ticks(20);
      step(1, 0, "b3", 1, 1, 0, 3'd2, 0, 0);
      ticks(20);
      step(1, 0, "b4", 1, 1, 0, 3'd3, 0, 0);
      ticks(20);
      step(1, 0, "b5_track", 1, 1, 0, 3'd4, 1, 0);

      // Artifact at ivl=5, then a beat at ivl=25 from the last accepted one.
      ticks(5);
      step(1, 0, "rej_ivl5", 0, 0, 1, 3'd4, 1, 0);
      ticks(20);
      step(1, 0, "acc_ivl25", 1, 1, 0, 3'd4, 1, 0);

      // Beat coincident with tick: pre-increment value is judged.
      ticks(11);
      step(1, 1, "rej_tick_ivl11", 0, 0, 1, 3'd4, 1, 0);
      step(1, 1, "acc_tick_ivl12", 1, 1, 0, 3'd4, 1, 0);
      // Interval must have restarted from 0 despite the coincident tick.
      ticks(11);
      step(1, 0, "rej_after_clr_ivl11", 0, 0, 1, 3'd4, 1, 0);
      ticks(1);
      step(1, 0, "acc_ivl12", 1, 1, 0, 3'd4, 1, 0);

      // Loss of signal: 63 ticks reach MAX, the following beatless cycle times out.
      ticks(63);
      chk("at_max.timeout", 8'(timeout), 8'd0);
      chk("at_max.avg_valid", 8'(avg_valid), 8'd1);
      step(0, 0, "timeout", 0, 0, 0, 3'd0, 0, 1);
      ticks(3);
      chk("lost_hold.timeout", 8'(timeout), 8'd1);
      step(1, 0, "lost_beat", 1, 0, 0, 3'd0, 0, 0);
      ticks(20);
      step(1, 0, "arm_after_lost", 1, 1, 0, 3'd1, 0, 0);

      // Beat in the cycle ivl==MAX is accepted, no timeout.
      ticks(63);
      chk("arm_at_max.timeout", 8'(timeout), 8'd0);
      step(1, 0, "acc_at_max", 1, 1, 0, 3'd2, 0, 0);
      ticks(20);
      step(1, 0, "b_ns3", 1, 1, 0, 3'd3, 0, 0);

      // Asynchronous reset between clock edges with nsamp=3.
      ticks(7);
      #2;
      rst = 1'b1;
      #1;
      chk_all_zero("async_rst");
      repeat (2) @(posedge clk);
      #1;
      chk_all_zero("rst_held");
      rst = 1'b0;
      ticks(30);
      step(1, 0, "post_rst_beat", 1, 0, 0, 3'd0, 0, 0);
      ticks(20);
      step(1, 0, "post_rst_b2", 1, 1, 0, 3'd1, 0, 0);

      chk("sb_empty", 8'(sb_q.size()), 8'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
